// File: rtl/cs_pkg.sv
// Shared widths and mode encodings for the sliding-window average unit.
// Imported by the selector and the top.
package cs_pkg;

    localparam logic CS_MODE_APPR = 1'b0;
    localparam logic CS_MODE_MAX  = 1'b1;

    // Running-sum width: holds DEPTH full-scale samples.
    function automatic int cs_sumw(input int dw, input int depth);
        return dw + $clog2(depth + 1);
    endfunction

    // Result width after the output shift.
    function automatic int cs_ow(input int dw, input int depth, input int shift);
        return cs_sumw(dw, depth) + 1 - shift;
    endfunction

endpackage

// File: rtl/cs_appr_select.sv
// Picks the largest window sample x with DEPTH*x <= Sum, plus the plain max.
// Both results come out of balanced max-reduction trees.
module cs_appr_select
    import cs_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 9,
    localparam int SUMW = cs_sumw(DW, DEPTH)
) (
    input  logic [DEPTH*DW-1:0] win,
    input  logic [SUMW-1:0]     sum,
    output logic [DW-1:0]       xappr,
    output logic [DW-1:0]       xmax
);

    localparam int L = $clog2(DEPTH);
    localparam int N = 1 << L;
    localparam logic [SUMW-1:0] DEP = SUMW'(DEPTH);

    for (genvar l = 0; l <= L; l++) begin : lv
        logic [DW-1:0] m [N>>l];
        logic [DW-1:0] a [N>>l];
        for (genvar i = 0; i < (N >> l); i++) begin : nd
            if (l == 0) begin : leaf
                if (i < DEPTH) begin : used
                    logic [DW-1:0]   x;
                    logic [SUMW-1:0] p;
                    assign x    = win[i*DW +: DW];
                    assign p    = DEP * {{(SUMW-DW){1'b0}}, x};
                    assign m[i] = x;
                    assign a[i] = (p <= sum) ? x : '0;
                end else begin : pad
                    assign m[i] = '0;
                    assign a[i] = '0;
                end
            end else begin : node
                logic [DW-1:0] ml, mr, al, ar;
                assign ml   = lv[l-1].m[2*i];
                assign mr   = lv[l-1].m[2*i+1];
                assign al   = lv[l-1].a[2*i];
                assign ar   = lv[l-1].a[2*i+1];
                assign m[i] = (ml > mr) ? ml : mr;
                assign a[i] = (al > ar) ? al : ar;
            end
        end
    end

    assign xmax  = lv[L].m[0];
    assign xappr = lv[L].a[0];

endmodule

// File: rtl/cs_window_approx.sv
// Sliding-window approximate average / max with fill tracking and flush.
// Stage 1 updates the window; stage 2 registers the selected result.
module cs_window_approx
    import cs_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 9,
    parameter int SHIFT = 3,
    localparam int SUMW = cs_sumw(DW, DEPTH),
    localparam int OW   = cs_ow(DW, DEPTH, SHIFT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] X,
    input  logic          mode,
    output logic          out_valid,
    output logic [OW-1:0] Y
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FULL = FW'(DEPTH);
    localparam logic [SUMW:0] DEP1 = (SUMW+1)'(DEPTH);

    logic [DW-1:0]       win [DEPTH];
    logic [DEPTH*DW-1:0] win_flat;
    logic [SUMW-1:0]     sum;
    logic [FW-1:0]       fill;
    logic [FW-1:0]       fill_nxt;
    logic                mode_r;
    logic                hit;
    logic [DW-1:0]       xappr;
    logic [DW-1:0]       xmax;
    logic [SUMW:0]       wide;
    logic [OW-1:0]       y_nxt;

    // Flatten the window for the selector and compute the next fill count.
    always_comb begin
        win_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            win_flat[i*DW +: DW] = win[i];
        end
        fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
    end

    cs_appr_select #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_sel (
        .win   (win_flat),
        .sum   (sum),
        .xappr (xappr),
        .xmax  (xmax)
    );

    // Result selection: approx average or zero-extended window max.
    always_comb begin
        wide  = DEP1 * {{(SUMW+1-DW){1'b0}}, xappr} + {1'b0, sum};
        y_nxt = OW'(wide >> SHIFT);
        if (mode_r == CS_MODE_MAX) begin
            y_nxt = OW'(xmax);
        end
    end

    // Stage 1: window shift, running sum, fill count and result qualifier.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            sum    <= '0;
            fill   <= '0;
            mode_r <= 1'b0;
            hit    <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            sum  <= '0;
            fill <= '0;
            hit  <= 1'b0;
        end else if (in_valid) begin
            win[0] <= X;
            for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
            sum    <= sum - SUMW'(win[DEPTH-1]) + SUMW'(X);
            fill   <= fill_nxt;
            mode_r <= mode;
            hit    <= (fill_nxt == FULL);
        end else begin
            hit <= 1'b0;
        end
    end

    // Stage 2: registered output; clear cancels a pending pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            Y         <= '0;
        end else begin
            out_valid <= hit && !clear;
            if (hit && !clear) begin
                Y <= y_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cs_window_approx.sv
// Scoreboard bench for cs_window_approx (DW=8, DEPTH=9, SHIFT=3).
// Stimulus pushes expected results; a monitor pops on each out_valid.
module tb_cs_window_approx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] X = '0;
    logic       mode = 1'b0;
    logic       out_valid;
    logic [9:0] Y;

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    cs_window_approx #(
        .DW    (8),
        .DEPTH (9),
        .SHIFT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .X         (X),
        .mode      (mode),
        .out_valid (out_valid),
        .Y         (Y)
    );

    // Monitor: every pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (out_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: Y=%0d, required no pulse", Y);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (Y !== e) begin
                    fails++;
                    $display("FAIL result: Y=%0d, required %0d", Y, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] x, input logic m, input logic clr);
        in_valid = 1'b1;
        X        = x;
        mode     = m;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic ramp(input int n, input logic m);
        for (int i = 1; i <= n; i++) send(8'(i), m, 1'b0);
    endtask

    initial begin
        #12;
        check("reset_out_valid", {9'd0, out_valid}, 10'd0);
        check("reset_Y", Y, 10'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Fill 1..9 approx, then slide in 10.
        exp_q.push_back(10'd11);
        ramp(9, 1'b0);
        exp_q.push_back(10'd13);
        send(8'd10, 1'b0, 1'b0);
        idle(3);
        check("fill_drained", 10'(exp_q.size()), 10'd0);

        // Full-scale constant window.
        do_clear();
        exp_q.push_back(10'd573);
        for (int i = 0; i < 9; i++) send(8'd255, 1'b0, 1'b0);
        idle(3);

        // Max mode then mixed modes per sample.
        do_clear();
        exp_q.push_back(10'd9);
        ramp(9, 1'b1);
        exp_q.push_back(10'd13);
        send(8'd10, 1'b0, 1'b0);
        exp_q.push_back(10'd11);
        send(8'd11, 1'b1, 1'b0);
        exp_q.push_back(10'd18);
        send(8'd12, 1'b0, 1'b0);
        idle(3);

        // Bubbles inside the fill.
        do_clear();
        exp_q.push_back(10'd11);
        for (int i = 1; i <= 9; i++) begin
            send(8'(i), 1'b0, 1'b0);
            idle(i % 3);
        end
        idle(3);
        check("bubble_drained", 10'(exp_q.size()), 10'd0);

        // Clear with the 9th sample drops it; refill required.
        do_clear();
        ramp(8, 1'b0);
        send(8'd9, 1'b0, 1'b1);
        idle(3);
        exp_q.push_back(10'd11);
        ramp(9, 1'b0);
        send(8'd10, 1'b0, 1'b0);
        do_clear();
        idle(3);
        check("clear_cancel", 10'(exp_q.size()), 10'd0);

        // Async reset mid-stream.
        ramp(5, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("areset_Y", Y, 10'd0);
        check("areset_out_valid", {9'd0, out_valid}, 10'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.push_back(10'd11);
        ramp(9, 1'b0);
        idle(4);
        check("final_drained", 10'(exp_q.size()), 10'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
